// File: rtl/usb_pkg.sv
// Shared definitions for the USB transmit path: PID codes, the packet
// sequencer state encoding and the CRC16 constants.
package usb_pkg;

  // PID nibbles as they appear in the low half of the PID byte.
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  // PID[1:0] distinguishes the packet class.
  localparam logic [1:0] PID_TYPE_HS   = 2'b10;
  localparam logic [1:0] PID_TYPE_DATA = 2'b11;

  // CRC16: polynomial 0x8005 processed LSB-first, so the shift register
  // uses the bit-reflected polynomial.
  localparam logic [15:0] CRC16_POLY     = 16'hA001;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_PAYLOAD,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_EOP,
    ST_DONE
  } tx_state_t;

endpackage

// File: rtl/usb_crc16_byte.sv
// Combinational CRC16 update for one byte, bits consumed LSB-first in the
// same order they leave on the wire.
module usb_crc16_byte
  import usb_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  // Eight unrolled shift/xor steps of the reflected CRC register.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' and assigns every output
    // first, so each loop step sees the previous one and no latch is inferred.
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0] ^ data_in[i]) begin
        crc_out = (crc_out >> 1) ^ CRC16_POLY;
      end else begin
        crc_out = crc_out >> 1;
      end
    end
  end

endmodule

// File: rtl/usb_tx_pkt_ctrl.sv
// Transmit packet sequencer: feeds SYNC, PID, payload and CRC16 bytes to the
// bit encoder one byte per byte_req, then requests EOP and reports status.
module usb_tx_pkt_ctrl
  import usb_pkg::*;
#(
  parameter int          MAX_LEN   = 64,
  parameter logic [7:0]  SYNC_BYTE = 8'h80
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [3:0] tx_pid,
  input  logic [6:0] tx_len,
  input  logic [7:0] fifo_rdata,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  input  logic       byte_req,
  input  logic       eop_done,
  output logic       sending,
  output logic [7:0] data,
  output logic       send_eop,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam logic [7:0] MAX_LEN_W = 8'(MAX_LEN);

  tx_state_t   state_q, state_d;
  logic [15:0] crc_q, crc_d, crc_next;
  logic [6:0]  rem_q, rem_d;
  logic [6:0]  len_q, len_d;
  logic [3:0]  pid_q, pid_d;
  logic        underrun_q, underrun_d;
  logic [7:0]  data_d;
  logic        sending_d, send_eop_d, fifo_rd_d, busy_d, done_d, error_d;
  logic        req_bad;

  usb_crc16_byte u_crc (
    .crc_in  (crc_q),
    .data_in (fifo_rdata),
    .crc_out (crc_next)
  );

  // A request is rejected for a non-handshake/non-data PID or an oversize data payload.
  always_comb begin
    req_bad = 1'b0;
    if (tx_pid[1:0] != PID_TYPE_HS && tx_pid[1:0] != PID_TYPE_DATA) begin
      req_bad = 1'b1;
    end else if (tx_pid[1:0] == PID_TYPE_DATA && {1'b0, tx_len} > MAX_LEN_W) begin
      req_bad = 1'b1;
    end
  end

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    rem_d      = rem_q;
    len_d      = len_q;
    pid_d      = pid_q;
    underrun_d = underrun_q;
    data_d     = data;
    sending_d  = sending;
    send_eop_d = send_eop;
    busy_d     = tx_busy;
    fifo_rd_d  = 1'b0;
    done_d     = 1'b0;
    error_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          if (req_bad) begin
            error_d = 1'b1;
          end else begin
            data_d     = SYNC_BYTE;
            sending_d  = 1'b1;
            busy_d     = 1'b1;
            crc_d      = CRC16_INIT;
            pid_d      = tx_pid;
            len_d      = tx_len;
            underrun_d = 1'b0;
            state_d    = ST_SYNC;
          end
        end
      end

      ST_SYNC: begin
        if (byte_req) begin
          data_d  = {~pid_q, pid_q};
          state_d = ST_PID;
        end
      end

      ST_PID: begin
        if (byte_req) begin
          if (pid_q[1:0] != PID_TYPE_DATA) begin
            send_eop_d = 1'b1;
            state_d    = ST_EOP;
          end else if (len_q == 7'd0) begin
            data_d  = ~crc_q[7:0];
            state_d = ST_CRC_LO;
          end else if (fifo_empty) begin
            // Nothing to send for the first payload byte: abort the packet.
            error_d    = 1'b1;
            underrun_d = 1'b1;
            send_eop_d = 1'b1;
            state_d    = ST_EOP;
          end else begin
            fifo_rd_d = 1'b1;
            data_d    = fifo_rdata;
            crc_d     = crc_next;
            rem_d     = len_q - 7'd1;
            state_d   = ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        if (byte_req) begin
          if (rem_q == 7'd0) begin
            data_d  = ~crc_q[7:0];
            state_d = ST_CRC_LO;
          end else if (fifo_empty) begin
            // Underrun: the packet is cut short and its CRC is never sent.
            error_d    = 1'b1;
            underrun_d = 1'b1;
            send_eop_d = 1'b1;
            state_d    = ST_EOP;
          end else begin
            fifo_rd_d = 1'b1;
            data_d    = fifo_rdata;
            crc_d     = crc_next;
            rem_d     = rem_q - 7'd1;
          end
        end
      end

      ST_CRC_LO: begin
        if (byte_req) begin
          data_d  = ~crc_q[15:8];
          state_d = ST_CRC_HI;
        end
      end

      ST_CRC_HI: begin
        if (byte_req) begin
          send_eop_d = 1'b1;
          state_d    = ST_EOP;
        end
      end

      ST_EOP: begin
        // byte_req is irrelevant here; only eop_done moves the sequencer on.
        if (eop_done) begin
          sending_d  = 1'b0;
          send_eop_d = 1'b0;
          done_d     = ~underrun_q;
          state_d    = ST_DONE;
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        data_d  = 8'h00;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and output registers; reset aborts any packet in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: sequential state uses non-blocking '<=' so all registers update
    // together from the values present before the edge.
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      crc_q      <= CRC16_INIT;
      rem_q      <= '0;
      len_q      <= '0;
      pid_q      <= '0;
      underrun_q <= 1'b0;
      data       <= 8'h00;
      sending    <= 1'b0;
      send_eop   <= 1'b0;
      fifo_rd    <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      rem_q      <= rem_d;
      len_q      <= len_d;
      pid_q      <= pid_d;
      underrun_q <= underrun_d;
      data       <= data_d;
      sending    <= sending_d;
      send_eop   <= send_eop_d;
      fifo_rd    <= fifo_rd_d;
      tx_busy    <= busy_d;
      tx_done    <= done_d;
      tx_error   <= error_d;
    end
  end

endmodule

// File: tb/tb_usb_tx_pkt_ctrl.sv
// Directed bench for usb_tx_pkt_ctrl: a behavioural encoder strobes byte_req
// and eop_done, a queue stands in for the FWFT Tx FIFO.
module tb_usb_tx_pkt_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [3:0] tx_pid = 4'h0;
  logic [6:0] tx_len = 7'd0;
  logic [7:0] fifo_rdata;
  logic       fifo_empty;
  logic       fifo_rd;
  logic       byte_req = 1'b0;
  logic       eop_done = 1'b0;
  logic       sending;
  logic [7:0] data;
  logic       send_eop;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  int total = 0;
  int bad   = 0;

  logic [7:0] fifo_q[$];
  int rd_cnt = 0;
  int rd_empty_cnt = 0;
  int done_cnt = 0;

  usb_tx_pkt_ctrl dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_start   (tx_start),
    .tx_pid     (tx_pid),
    .tx_len     (tx_len),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .byte_req   (byte_req),
    .eop_done   (eop_done),
    .sending    (sending),
    .data       (data),
    .send_eop   (send_eop),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (fifo_q.size() == 0);
  assign fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;

  // FIFO pop model plus event counters.
  always @(posedge clk) begin
    if (fifo_rd) begin
      rd_cnt++;
      if (fifo_q.size() == 0) rd_empty_cnt++;
      else void'(fifo_q.pop_front());
    end
    if (tx_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic [3:0] pid, input logic [6:0] len);
    @(negedge clk);
    tx_start = 1'b1;
    tx_pid   = pid;
    tx_len   = len;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Encoder asks for the next byte every 8 bit-times.
  task automatic byte_step();
    repeat (7) @(negedge clk);
    byte_req = 1'b1;
    @(negedge clk);
    byte_req = 1'b0;
  endtask

  // Encoder finishes SE0,SE0,J; returns in the DONE cycle.
  task automatic finish_eop();
    repeat (3) @(negedge clk);
    eop_done = 1'b1;
    @(negedge clk);
    eop_done = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  pkt [6];
    logic [15:0] r;
    logic        fb;
    int          d0;
    int          r0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_sending",  16'(sending),  16'h0);
    check("rst_data",     16'(data),     16'h00);
    check("rst_send_eop", 16'(send_eop), 16'h0);
    check("rst_fifo_rd",  16'(fifo_rd),  16'h0);
    check("rst_busy",     16'(tx_busy),  16'h0);
    check("rst_done",     16'(tx_done),  16'h0);
    check("rst_error",    16'(tx_error), 16'h0);
    n_rst = 1'b1;

    // ACK handshake: SYNC, PID, EOP
    d0 = done_cnt;
    start_req(4'b0010, 7'd0);
    check("ack_sync",    16'(data),    16'h80);
    check("ack_sending", 16'(sending), 16'h1);
    check("ack_busy",    16'(tx_busy), 16'h1);
    byte_step();
    check("ack_pid", 16'(data), 16'hD2);
    byte_step();
    check("ack_eop",      16'(send_eop), 16'h1);
    check("ack_eop_send", 16'(sending),  16'h1);
    finish_eop();
    check("ack_done",      16'(tx_done),  16'h1);
    check("ack_done_busy", 16'(tx_busy),  16'h1);
    check("ack_done_send", 16'(sending),  16'h0);
    check("ack_done_eop",  16'(send_eop), 16'h0);
    @(negedge clk);
    check("ack_done_off", 16'(tx_done), 16'h0);
    check("ack_idle_busy", 16'(tx_busy), 16'h0);
    check("ack_done_cnt", 16'(done_cnt - d0), 16'd1);

    // DATA0, zero-length payload: CRC of nothing is ~FFFF = 0000
    r0 = rd_cnt;
    start_req(4'b0011, 7'd0);
    check("d0z_sync", 16'(data), 16'h80);
    byte_step();
    check("d0z_pid", 16'(data), 16'hC3);
    byte_step();
    check("d0z_crc_lo", 16'(data), 16'h00);
    byte_step();
    check("d0z_crc_hi", 16'(data), 16'h00);
    byte_step();
    check("d0z_eop", 16'(send_eop), 16'h1);
    finish_eop();
    check("d0z_done", 16'(tx_done), 16'h1);
    @(negedge clk);
    check("d0z_no_rd", 16'(rd_cnt - r0), 16'd0);

    // DATA1, 4 bytes 00..03: CRC16 = 8510, sent as EF, 7A
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'(i));
    r0 = rd_cnt;
    start_req(4'b1011, 7'd4);
    check("d1_sync", 16'(data), 16'h80);
    byte_step();
    check("d1_pid", 16'(data), 16'h4B);
    for (int i = 0; i < 4; i++) begin
      byte_step();
      check("d1_payload", 16'(data), 16'(i));
      pkt[i] = data;
    end
    byte_step();
    check("d1_crc_lo", 16'(data), 16'h00EF);
    pkt[4] = data;
    byte_step();
    check("d1_crc_hi", 16'(data), 16'h007A);
    pkt[5] = data;
    byte_step();
    check("d1_eop", 16'(send_eop), 16'h1);
    // Receiver-side check: MSB-first polynomial division over wire-order bits.
    r = 16'hFFFF;
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 8; j++) begin
        fb = r[15] ^ pkt[k][j];
        r  = {r[14:0], 1'b0};
        if (fb) r = r ^ 16'h8005;
      end
    end
    check("d1_residual", r, 16'h800D);
    finish_eop();
    check("d1_done", 16'(tx_done), 16'h1);
    @(negedge clk);
    check("d1_rd_pulses", 16'(rd_cnt - r0), 16'd4);
    check("d1_fifo_drained", 16'(fifo_q.size()), 16'd0);

    // DATA0, tx_len=3 but only 2 bytes queued: underrun
    fifo_q.push_back(8'hAA);
    fifo_q.push_back(8'h55);
    d0 = done_cnt;
    start_req(4'b0011, 7'd3);
    byte_step();
    check("ur_pid", 16'(data), 16'hC3);
    byte_step();
    check("ur_b0", 16'(data), 16'hAA);
    byte_step();
    check("ur_b1", 16'(data), 16'h55);
    byte_step();
    check("ur_error", 16'(tx_error), 16'h1);
    check("ur_eop",   16'(send_eop), 16'h1);
    check("ur_hold",  16'(data),     16'h55);
    @(negedge clk);
    check("ur_error_pulse", 16'(tx_error), 16'h0);
    finish_eop();
    check("ur_no_done", 16'(tx_done), 16'h0);
    @(negedge clk);
    check("ur_done_cnt", 16'(done_cnt - d0), 16'd0);
    check("ur_idle_busy", 16'(tx_busy), 16'h0);

    // Illegal requests
    start_req(4'b0001, 7'd0);
    check("tok_error",   16'(tx_error), 16'h1);
    check("tok_sending", 16'(sending),  16'h0);
    check("tok_busy",    16'(tx_busy),  16'h0);
    @(negedge clk);
    check("tok_pulse", 16'(tx_error), 16'h0);
    start_req(4'b0011, 7'd65);
    check("len65_error",   16'(tx_error), 16'h1);
    check("len65_sending", 16'(sending),  16'h0);

    // tx_len=64 is legal; reset lands while fifo_rd is high in PAYLOAD
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h33);
    start_req(4'b0011, 7'd64);
    check("len64_ok", 16'(sending), 16'h1);
    byte_step();
    byte_step();
    check("rstmid_b0", 16'(data),    16'h11);
    check("rstmid_rd", 16'(fifo_rd), 16'h1);
    #2;
    n_rst = 1'b0;
    #1;
    check("rstmid_sending",  16'(sending),  16'h0);
    check("rstmid_data",     16'(data),     16'h00);
    check("rstmid_send_eop", 16'(send_eop), 16'h0);
    check("rstmid_fifo_rd",  16'(fifo_rd),  16'h0);
    check("rstmid_busy",     16'(tx_busy),  16'h0);
    fifo_q.delete();
    @(negedge clk);
    n_rst = 1'b1;

    // Normal ACK after the abort
    start_req(4'b0010, 7'd0);
    check("ack2_sync", 16'(data), 16'h80);
    byte_step();
    check("ack2_pid", 16'(data), 16'hD2);
    byte_step();
    check("ack2_eop", 16'(send_eop), 16'h1);
    finish_eop();
    check("ack2_done", 16'(tx_done), 16'h1);
    @(negedge clk);
    check("rd_while_empty", 16'(rd_empty_cnt), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
